// File: rtl/demux8_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux8_pkg : shared types/constants for the 8-channel demux     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package demux8_pkg;

    localparam int CHANNELS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [CHANNELS-1:0] sel_to_onehot(input logic [2:0] sel);
        return CHANNELS'(1) << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demultiplexer8_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux8_if : byte-stream handshake plus fanned-out channel bus   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface demux8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             ready;
    logic             x;
    logic             y;
    logic             z;
    logic             auto;
    logic [WIDTH-1:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic [7:0]       stb;
    logic [2:0]       ch;
    logic             frame_done;

    modport master (
        output din, valid, x, y, z, auto,
        input  ready, o1, o2, o3, o4, o5, o6, o7, o8, stb, ch, frame_done
    );

    modport slave (
        input  din, valid, x, y, z, auto,
        output ready, o1, o2, o3, o4, o5, o6, o7, o8, stb, ch, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/demux8_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux8_scan_ctrl : routing FSM, scan counter, one-hot write en  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module demux8_scan_ctrl
    import demux8_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                clr,
    input  wire logic                valid,
    input  wire logic                x,
    input  wire logic                y,
    input  wire logic                z,
    input  wire logic                auto,
    output logic                     ready,
    output logic [2:0]               ch,
    output logic                     frame_done,
    output logic [CHANNELS-1:0]      we
);
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       fd_q, fd_d;
    logic       w_accept;

    always_comb begin
        ready = (state_q != ST_DONE);
        case (state_q)
            ST_IDLE: ch = auto ? 3'd0 : {x, y, z};
            ST_SCAN: ch = cnt_q;
            default: ch = 3'd0;
        endcase

        // a clear drops any transfer presented in the same cycle
        w_accept = valid & ready & ~clr;
        we       = w_accept ? sel_to_onehot(ch) : '0;

        state_d = state_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (w_accept && auto) begin
                    cnt_d   = 3'd1;
                    state_d = ST_SCAN;
                end
                ST_SCAN: if (w_accept) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                        fd_d    = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
        end
    end

    assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: rtl/demultiplexer8_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demultiplexer8_seq : registered 1-to-8 byte distributor         |
// | Optional synchronous clear input when DEMUX8_CLEAR_EN defined.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module demultiplexer8_seq
    import demux8_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic clk,
    input  wire logic rst_n,
`ifdef DEMUX8_CLEAR_EN
    input  wire logic clr,
`endif
    demux8_if.slave   bus
);
    logic                w_clr;
    logic [CHANNELS-1:0] w_we;
    logic [CHANNELS-1:0] stb_q, stb_d;
    logic [WIDTH-1:0]    o_q [CHANNELS];
    logic [WIDTH-1:0]    o_d [CHANNELS];

`ifdef DEMUX8_CLEAR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    demux8_scan_ctrl u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_clr),
        .valid      (bus.valid),
        .x          (bus.x),
        .y          (bus.y),
        .z          (bus.z),
        .auto       (bus.auto),
        .ready      (bus.ready),
        .ch         (bus.ch),
        .frame_done (bus.frame_done),
        .we         (w_we)
    );

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            always_comb begin
                o_d[k] = o_q[k];
                if (w_clr)
                    o_d[k] = RST_VAL;
                else if (w_we[k])
                    o_d[k] = bus.din;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    o_q[k] <= RST_VAL;
                else
                    o_q[k] <= o_d[k];
            end
        end
    endgenerate

    always_comb begin
        stb_d = w_clr ? '0 : w_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stb_q <= '0;
        else
            stb_q <= stb_d;
    end

    assign bus.stb = stb_q;
    assign bus.o1  = o_q[0];
    assign bus.o2  = o_q[1];
    assign bus.o3  = o_q[2];
    assign bus.o4  = o_q[3];
    assign bus.o5  = o_q[4];
    assign bus.o6  = o_q[5];
    assign bus.o7  = o_q[6];
    assign bus.o8  = o_q[7];

endmodule
`default_nettype wire

// File: tb/tb_demultiplexer8_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_demultiplexer8_seq : directed vector bench for the demux     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_demultiplexer8_seq;

    typedef struct {
        logic       valid;
        logic       auto_m;
        logic [2:0] sel;
        logic [7:0] din;
        logic [7:0] exp_stb;
        logic       exp_fd;
        logic       exp_rdy;
        logic [2:0] exp_ch;
    } vec_t;

    logic clk;
    logic rst_n;
`ifdef DEMUX8_CLEAR_EN
    logic clr;
`endif

    int n_cmp;
    int n_bad;
    logic [7:0] exp_o [8];
    vec_t tbl [14];

    demux8_if #(.WIDTH(8)) bus ();

    demultiplexer8_seq #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DEMUX8_CLEAR_EN
        .clr   (clr),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic a, input logic [2:0] sel, input logic [7:0] d);
        bus.valid = v;
        bus.auto  = a;
        {bus.x, bus.y, bus.z} = sel;
        bus.din   = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_pack();
        return {exp_o[7], exp_o[6], exp_o[5], exp_o[4], exp_o[3], exp_o[2], exp_o[1], exp_o[0]};
    endfunction

    task automatic chk_all(input string tag, input logic [7:0] stb, input logic fd,
                           input logic rdy, input logic [2:0] ch);
        chk({tag, ".stb"},   64'(bus.stb), 64'(stb));
        chk({tag, ".fd"},    64'(bus.frame_done), 64'(fd));
        chk({tag, ".ready"}, 64'(bus.ready), 64'(rdy));
        chk({tag, ".ch"},    64'(bus.ch), 64'(ch));
        chk({tag, ".o"},     {bus.o8, bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1},
            exp_pack());
    endtask

    task automatic apply_model(input logic [7:0] stb, input logic [7:0] d);
        for (int k = 0; k < 8; k++)
            if (stb[k]) exp_o[k] = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < 8; k++) exp_o[k] = 8'h00;
`ifdef DEMUX8_CLEAR_EN
        clr = 1'b0;
`endif
        //                valid auto sel   din    stb    fd rdy ch
        tbl[0]  = '{1'b1, 1'b0, 3'd4, 8'hCC, 8'h10, 1'b0, 1'b1, 3'd4};
        tbl[1]  = '{1'b0, 1'b0, 3'd2, 8'h11, 8'h00, 1'b0, 1'b1, 3'd2};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 8'h01, 8'h01, 1'b0, 1'b1, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 3'd7, 8'h7F, 8'h80, 1'b0, 1'b1, 3'd7};
        tbl[4]  = '{1'b1, 1'b1, 3'd5, 8'hAA, 8'h01, 1'b0, 1'b1, 3'd1};
        tbl[5]  = '{1'b1, 1'b1, 3'd5, 8'hBA, 8'h02, 1'b0, 1'b1, 3'd2};
        tbl[6]  = '{1'b1, 1'b1, 3'd5, 8'hBB, 8'h04, 1'b0, 1'b1, 3'd3};
        tbl[7]  = '{1'b1, 1'b1, 3'd5, 8'hCB, 8'h08, 1'b0, 1'b1, 3'd4};
        tbl[8]  = '{1'b1, 1'b1, 3'd5, 8'hCC, 8'h10, 1'b0, 1'b1, 3'd5};
        tbl[9]  = '{1'b1, 1'b1, 3'd5, 8'hDC, 8'h20, 1'b0, 1'b1, 3'd6};
        tbl[10] = '{1'b1, 1'b1, 3'd5, 8'hDD, 8'h40, 1'b0, 1'b1, 3'd7};
        tbl[11] = '{1'b1, 1'b1, 3'd5, 8'hFF, 8'h80, 1'b1, 1'b0, 3'd0};
        // byte offered during DONE is not consumed, then taken in IDLE
        tbl[12] = '{1'b1, 1'b0, 3'd3, 8'h99, 8'h00, 1'b0, 1'b1, 3'd3};
        tbl[13] = '{1'b1, 1'b0, 3'd3, 8'h99, 8'h08, 1'b0, 1'b1, 3'd3};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk_all("reset", 8'h00, 1'b0, 1'b1, 3'd0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].valid, tbl[i].auto_m, tbl[i].sel, tbl[i].din);
            step();
            apply_model(tbl[i].exp_stb, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].exp_stb, tbl[i].exp_fd,
                    tbl[i].exp_rdy, tbl[i].exp_ch);
        end

        // auto frame with a 3-cycle stall after byte 3, auto dropped meanwhile
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic [7:0] s;
            d = 8'(8'h11 * (i + 1));
            s = 8'(8'h01 << i);
            if (i == 3) begin
                drive(1'b0, 1'b0, 3'd6, 8'hEE);
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk_all($sformatf("stall%0d", j), 8'h00, 1'b0, 1'b1, 3'd3);
                end
            end
            drive(1'b1, (i < 3), 3'd6, d);
            step();
            apply_model(s, d);
            chk_all($sformatf("stallfr%0d", i), s, (i == 7), (i != 7),
                    (i == 7) ? 3'd0 : 3'(i + 1));
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        step();
        chk_all("after_done", 8'h00, 1'b0, 1'b1, 3'd0);

        // asynchronous reset in the middle of an auto frame
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 3'd0, 8'(8'hA1 + i));
            step();
            apply_model(8'(8'h01 << i), 8'(8'hA1 + i));
            chk_all($sformatf("rfr%0d", i), 8'(8'h01 << i), 1'b0, 1'b1, 3'(i + 1));
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) exp_o[k] = 8'h00;
        chk_all("async_rst", 8'h00, 1'b0, 1'b1, 3'd0);
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b1, 3'd0, 8'hB1);
        step();
        apply_model(8'h01, 8'hB1);
        chk_all("post_rst", 8'h01, 1'b0, 1'b1, 3'd1);

`ifdef DEMUX8_CLEAR_EN
        // clear beats a simultaneous transfer and aborts the running frame
        clr = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 8'h5A);
        step();
        for (int k = 0; k < 8; k++) exp_o[k] = 8'h00;
        chk_all("clr", 8'h00, 1'b0, 1'b1, 3'd2);
        clr = 1'b0;
        step();
        apply_model(8'h04, 8'h5A);
        chk_all("post_clr", 8'h04, 1'b0, 1'b1, 3'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
